freq_meas_seq: RTL

Sequencer for the square-wave frequency/duty measurement path. On `start` it arms on a rising edge of the measured signal and opens a gate. It keeps the gate open for at least `GATE_CYCLES` system clocks, then closes it on the next rising edge. This is the equal-precision (whole-period) method. It reports reference-cycle, signal-period and high-time counts through a valid/ready result port, and drives `gate_o` so the 200 MHz PLL-domain counters can follow the same window.

---
 rtl/freq_meas_pkg.sv | 14 +
 rtl/sig_edge_sync.sv | 39 +++
 rtl/freq_meas_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared constants for the frequency/duty measurement sequencer
// Contents: 2-bit state encoding and default counter/gate/watchdog sizes.
package freq_meas_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_GATE = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int          DEF_CNT_W          = 32;
    localparam int unsigned DEF_GATE_CYCLES    = 50_000_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100_000_000;

endpackage

// File: rtl/sig_edge_sync.sv
// rtl/sig_edge_sync.sv - multi-flop synchronizer with rising-edge detect
// Ports:
//   clk     in   sampling clock
//   rst     in   synchronous active-high reset
//   sig_in  in   asynchronous input level
//   sig_lvl out  synchronized level (last synchronizer stage)
//   rise    out  one-cycle pulse on a synchronized 0->1 transition
module sig_edge_sync
    import freq_meas_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_lvl_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sig_lvl = r_sync[SYNC_STAGES-1];
    assign rise    = r_sync[SYNC_STAGES-1] & ~r_lvl_d;

endmodule

// File: rtl/freq_meas_seq.sv
// rtl/freq_meas_seq.sv - equal-precision gate sequencer for frequency/duty measurement
// Ports:
//   sys_clk, sys_rst            clock and synchronous active-high reset
//   sig_in                      measured square wave (asynchronous)
//   start, abort                measurement request / cancel
//   result_ready                consumer handshake for the result
//   busy, gate_o                activity flag and gate window (followed by PLL-domain counters)
//   result_valid, timeout       result qualifier; timeout=1 means watchdog ended the run
//   ref_cnt, sig_cnt, high_cnt  reference cycles, whole periods, high cycles inside the gate
module freq_meas_seq
    import freq_meas_pkg::*;
#(
    parameter int          CNT_W          = DEF_CNT_W,
    parameter int unsigned GATE_CYCLES    = DEF_GATE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             abort,
    input  logic             result_ready,
    output logic             busy,
    output logic             gate_o,
    output logic             result_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] ref_cnt,
    output logic [CNT_W-1:0] sig_cnt,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] GATE_LIM = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(TIMEOUT_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             w_sig_lvl;
    logic             w_rise;
    logic [CNT_W-1:0] w_ref_n;
    logic [CNT_W-1:0] w_sig_n;
    logic [CNT_W-1:0] w_high_n;
    logic [CNT_W-1:0] w_wdog_n;
    logic             w_wdog_hit;
    logic             w_close;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_ref_cnt;
    logic [CNT_W-1:0] r_sig_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_wdog;
    logic             r_timeout;

    sig_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .sig_in  (sig_in),
        .sig_lvl (w_sig_lvl),
        .rise    (w_rise)
    );

    assign w_ref_n    = sat_inc(r_ref_cnt);
    assign w_sig_n    = w_rise    ? sat_inc(r_sig_cnt)  : r_sig_cnt;
    assign w_high_n   = w_sig_lvl ? sat_inc(r_high_cnt) : r_high_cnt;
    assign w_wdog_n   = sat_inc(r_wdog);
    assign w_wdog_hit = (w_wdog_n >= WDOG_LIM);
    // The closing cycle is part of the window, so compare the post-increment count.
    assign w_close    = w_rise && (w_ref_n >= GATE_LIM);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_ref_cnt  <= '0;
            r_sig_cnt  <= '0;
            r_high_cnt <= '0;
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_ARM;
                        r_ref_cnt  <= '0;
                        r_sig_cnt  <= '0;
                        r_high_cnt <= '0;
                        r_wdog     <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_ARM, ST_GATE: begin
                    r_wdog <= w_wdog_n;
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_ref_cnt  <= '0;
                        r_sig_cnt  <= '0;
                        r_high_cnt <= '0;
                        r_timeout  <= 1'b0;
                    end else if (w_wdog_hit) begin
                        // A timed-out run reports no partial counts.
                        r_state    <= ST_DONE;
                        r_ref_cnt  <= '0;
                        r_sig_cnt  <= '0;
                        r_high_cnt <= '0;
                        r_timeout  <= 1'b1;
                    end else if (r_state == ST_ARM) begin
                        // The opening edge itself is not counted.
                        if (w_rise) begin
                            r_state    <= ST_GATE;
                            r_ref_cnt  <= '0;
                            r_sig_cnt  <= '0;
                            r_high_cnt <= '0;
                        end
                    end else begin
                        r_ref_cnt  <= w_ref_n;
                        r_sig_cnt  <= w_sig_n;
                        r_high_cnt <= w_high_n;
                        if (w_close) begin
                            r_state   <= ST_DONE;
                            r_timeout <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || result_ready) begin
                        r_state    <= ST_IDLE;
                        r_ref_cnt  <= '0;
                        r_sig_cnt  <= '0;
                        r_high_cnt <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign gate_o       = (r_state == ST_GATE);
    assign result_valid = (r_state == ST_DONE);
    assign timeout      = r_timeout;
    assign ref_cnt      = r_ref_cnt;
    assign sig_cnt      = r_sig_cnt;
    assign high_cnt     = r_high_cnt;

endmodule
